// File: rtl/acc_cfg_sched.sv
// Accepts a delay/hold request, waits for a quiet accumulation window (or a timeout), applies it and masks the
// accumulation flag until the delay line has flushed; ready only when idle, so requesters hold valid until accepted.
module acc_cfg_sched #(
  parameter real         TCQ         = 0.1,
  parameter int unsigned QUIET_UNITS = 16,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [17:0] cfg_delay_i,
  input  logic [15:0] cfg_hold_i,
  input  logic        filter_unit_flag_i,
  input  logic        filter_acc_flag_i,
  output logic [17:0] acc_delay_o,
  output logic [15:0] acc_hold_o,
  output logic        acc_mask_o,
  output logic        busy_o,
  output logic        timeout_o
);

  if (TCQ < 0.0 || QUIET_UNITS < 1 || QUIET_UNITS > 65535 ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32'd16777216) begin : g_bad_param
    $error("acc_cfg_sched: parameter out of range");
  end

  localparam logic [15:0] QUIET_LIM = 16'(QUIET_UNITS);
  // Compared against the pre-increment count so APPLY lands on the edge where the count would reach TIMEOUT_CYC-1.
  localparam logic [23:0] TMO_LIM   = 24'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_QUIET,
    ST_APPLY,
    ST_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] quiet_q, quiet_d;
  logic [23:0] tmo_q, tmo_d;
  logic [16:0] flush_q, flush_d;
  logic [17:0] sh_delay_q, sh_delay_d;
  logic [15:0] sh_hold_q, sh_hold_d;
  logic [17:0] acc_delay_d;
  logic [15:0] acc_hold_d;
  logic        timeout_d;
  logic        ready_d;
  logic        busy_d;
  logic        mask_d;

  always_comb begin
    state_d     = state_q;
    quiet_d     = quiet_q;
    tmo_d       = tmo_q;
    flush_d     = flush_q;
    sh_delay_d  = sh_delay_q;
    sh_hold_d   = sh_hold_q;
    acc_delay_d = acc_delay_o;
    acc_hold_d  = acc_hold_o;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        quiet_d = '0;
        tmo_d   = '0;
        if (cfg_valid_i && cfg_ready_o) begin
          sh_delay_d = cfg_delay_i;
          sh_hold_d  = cfg_hold_i;
          state_d    = ST_WAIT_QUIET;
        end
      end
      ST_WAIT_QUIET: begin
        tmo_d = tmo_q + 24'd1;
        // An accumulating cycle restarts the quiet window even if a unit strobe arrives with it.
        if (filter_acc_flag_i)
          quiet_d = '0;
        else if (filter_unit_flag_i)
          quiet_d = quiet_q + 16'd1;
        if (tmo_q == TMO_LIM) begin
          state_d   = ST_APPLY;
          timeout_d = 1'b1;
        end else if (quiet_q == QUIET_LIM) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        acc_delay_d = sh_delay_q;
        acc_hold_d  = sh_hold_q;
        flush_d     = {1'b0, sh_hold_q} + 17'd2;
        quiet_d     = '0;
        tmo_d       = '0;
        state_d     = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_q == 17'd0)
          state_d = ST_IDLE;
        else if (filter_unit_flag_i)
          flush_d = flush_q - 17'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    mask_d  = (state_d == ST_APPLY) || (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      quiet_q     <= '0;
      tmo_q       <= '0;
      flush_q     <= '0;
      sh_delay_q  <= '0;
      sh_hold_q   <= '0;
      acc_delay_o <= '0;
      acc_hold_o  <= '0;
      acc_mask_o  <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
      cfg_ready_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      quiet_q     <= quiet_d;
      tmo_q       <= tmo_d;
      flush_q     <= flush_d;
      sh_delay_q  <= sh_delay_d;
      sh_hold_q   <= sh_hold_d;
      acc_delay_o <= acc_delay_d;
      acc_hold_o  <= acc_hold_d;
      acc_mask_o  <= mask_d;
      busy_o      <= busy_d;
      timeout_o   <= timeout_d;
      cfg_ready_o <= ready_d;
    end
  end

endmodule
